// File: rtl/alu_exec_stage.sv
// Registered execute stage: one combinational alu fed by a 2-entry elastic
// buffer (output reg R + skid reg S) with valid/ready handshakes on both sides.

// Combinational 32-bit alu: XOR / ADD / SUB / signed SLT, plus full-width A==B.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_c,
  output logic             eq_c
);

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  logic lt_c;

  // Signed less-than used by SLT.
  always_comb begin
    lt_c = ($signed(a) < $signed(b));
  end

  // Operation select; arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    result_c = '0;
    unique case (op)
      OP_XOR:  result_c = a ^ b;
      OP_ADD:  result_c = a + b;
      OP_SUB:  result_c = a - b;
      OP_SLT:  result_c = {{(WIDTH-1){1'b0}}, lt_c};
      default: result_c = '0;
    endcase
  end

  // Equality flag is produced for every op.
  always_comb begin
    eq_c = (a == b);
  end

endmodule

module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_eq,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned OP_W = 2;

  // Buffer occupancy: EMPTY (nothing), ONE (R full), FULL (R and S full).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Skid entry keeps the raw operands so the alu is evaluated on drain.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } skid_t;

  state_t           state;
  skid_t            skid;

  logic             in_xfer_c;
  logic             out_xfer_c;
  logic             use_skid_c;
  logic [OP_W-1:0]  alu_op_c;
  logic [WIDTH-1:0] alu_a_c;
  logic [WIDTH-1:0] alu_b_c;
  logic [TAG_W-1:0] alu_tag_c;
  logic [WIDTH-1:0] alu_result_c;
  logic             alu_eq_c;

  // Handshake qualifiers; in_ready and out_valid are both registered.
  always_comb begin
    in_xfer_c  = in_valid & in_ready;
    out_xfer_c = out_valid & out_ready;
  end

  // ALU input mux: the older skid entry has priority over the ports.
  always_comb begin
    use_skid_c = (state == ST_FULL);
    alu_op_c   = in_op;
    alu_a_c    = in_a;
    alu_b_c    = in_b;
    alu_tag_c  = in_tag;
    if (use_skid_c) begin
      alu_op_c  = skid.op;
      alu_a_c   = skid.a;
      alu_b_c   = skid.b;
      alu_tag_c = skid.tag;
    end
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op       (alu_op_c),
    .a        (alu_a_c),
    .b        (alu_b_c),
    .result_c (alu_result_c),
    .eq_c     (alu_eq_c)
  );

  // Occupancy FSM with registered handshake outputs and data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_eq     <= 1'b0;
      out_tag    <= '0;
      skid       <= '0;
    end else if (flush) begin
      // Drop every buffered op; data regs keep stale values.
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_xfer_c) begin
            out_result <= alu_result_c;
            out_eq     <= alu_eq_c;
            out_tag    <= alu_tag_c;
            out_valid  <= 1'b1;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer_c && out_xfer_c) begin
            // Back-to-back: replace the drained result with the new one.
            out_result <= alu_result_c;
            out_eq     <= alu_eq_c;
            out_tag    <= alu_tag_c;
          end else if (in_xfer_c) begin
            // R is stalled: park the incoming op in the skid register.
            skid.op  <= in_op;
            skid.a   <= in_a;
            skid.b   <= in_b;
            skid.tag <= in_tag;
            in_ready <= 1'b0;
            state    <= ST_FULL;
          end else if (out_xfer_c) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer_c) begin
            // Drain: evaluate the skid entry into R and reopen the input.
            out_result <= alu_result_c;
            out_eq     <= alu_eq_c;
            out_tag    <= alu_tag_c;
            in_ready   <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_eq;
  logic [TAG_W-1:0] out_tag;

  int checks;
  int errors;

  alu_exec_stage #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_eq     (out_eq),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);
    step(); step();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    checks++;
    if (out_result !== 32'h0 || out_eq !== 1'b0 || out_tag !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: result=%h eq=%b tag=%0d, want 0 0 0", out_result, out_eq, out_tag);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 32'd5, 32'd7, 5'd3);
    step();
    drive(1'b0, 2'b00, '0, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd12 || out_eq !== 1'b0 || out_tag !== 5'd3) begin
      errors++;
      $display("FAIL basic_add: v=%b result=%0d eq=%b tag=%0d, want 1 12 0 3",
               out_valid, out_result, out_eq, out_tag);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_signed();
    logic [1:0]       ops [6] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01};
    logic [WIDTH-1:0] as  [6] = '{32'hFFFF_FFFF, 32'd0, 32'hA5A5_A5A5, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [WIDTH-1:0] bs  [6] = '{32'd1, 32'd1, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
    logic [WIDTH-1:0] exp [6] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    logic             eqx [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], TAG_W'(i + 10));
      step();
      drive(1'b0, 2'b00, '0, '0, '0);
      checks++;
      if (out_valid !== 1'b1 || out_result !== exp[i] || out_eq !== eqx[i] || out_tag !== TAG_W'(i + 10)) begin
        errors++;
        $display("FAIL signed_%0d: v=%b result=%h eq=%b tag=%0d, want 1 %h %b %0d",
                 i, out_valid, out_result, out_eq, out_tag, exp[i], eqx[i], i + 10);
      end
      step();
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b01, WIDTH'(i), 32'd100, TAG_W'(i));
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== WIDTH'(100 + i) || out_tag !== TAG_W'(i)) begin
        errors++;
        $display("FAIL stream_%0d: v=%b rdy=%b result=%0d tag=%0d, want 1 1 %0d %0d",
                 i, out_valid, in_ready, out_result, out_tag, 100 + i, i);
      end
    end
    drive(1'b0, 2'b00, '0, '0, '0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'd10, 32'd20, 5'd1);
    step();
    drive(1'b1, 2'b10, 32'd50, 32'd8, 5'd2);
    step();
    drive(1'b0, 2'b00, '0, '0, '0);
  endtask

  task automatic test_backpressure();
    fill_two();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd30 || out_tag !== 5'd1) begin
      errors++;
      $display("FAIL bp_full: rdy=%b v=%b result=%0d tag=%0d, want 0 1 30 1",
               in_ready, out_valid, out_result, out_tag);
    end
    step(); step();
    checks++;
    if (out_result !== 32'd30 || out_tag !== 5'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: v=%b rdy=%b result=%0d tag=%0d, want 1 0 30 1",
               out_valid, in_ready, out_result, out_tag);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd42 || out_tag !== 5'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: v=%b rdy=%b result=%0d tag=%0d, want 1 1 42 2",
               out_valid, in_ready, out_result, out_tag);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: v=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    fill_two();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: v=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    // Flush beats a same-cycle input transfer.
    drive(1'b1, 2'b01, 32'd1, 32'd1, 5'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: v=%b, want 0", out_valid);
    end
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'h0000_00F0, 32'h0000_000F, 5'd7);
    step();
    drive(1'b0, 2'b00, '0, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000_00FF || out_eq !== 1'b0 || out_tag !== 5'd7) begin
      errors++;
      $display("FAIL flush_next: v=%b result=%h eq=%b tag=%0d, want 1 000000ff 0 7",
               out_valid, out_result, out_eq, out_tag);
    end
    step();
  endtask

  task automatic test_reset_mid();
    fill_two();
    reset = 1'b1;
    drive(1'b1, 2'b01, 32'd3, 32'd4, 5'd5);
    step();
    reset = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd0 || out_tag !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: v=%b rdy=%b result=%0d tag=%0d, want 0 1 0 0",
               out_valid, in_ready, out_result, out_tag);
    end
    out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: v=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_signed();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
